maxpool_2x2: RTL and testbench
==============================

// Module: maxpool_2x2
// PURPOSE
//   Downstream stage of the 3x3 convolution engine. Consumes the raster-ordered
//   6x6 feature map of 16-bit results that the conv stage streams out.
//   Applies 2x2 stride-2 max pooling and emits a raster-ordered 3x3 map.
//   Uses a one-line partial-max buffer, so the input needs no frame storage.
// PARAMETERS
//   DATA_W  16  sample width, unsigned, for input and output
//   IN_DIM  6   input frame width and height; must be even and >= 2
// PORTS
//   clk         in   1       rising-edge clock
//   rst_n       in   1       asynchronous active-low reset
//   in_vld      in   1       din holds a valid sample this cycle; driven from conv out_st
//   din         in   DATA_W  conv result, raster order (row-major, row 0 first)
//   dout        out  DATA_W  pooled value, raster order over the 3x3 output
//   out_vld     out  1       dout is valid this cycle (single-cycle pulse per output)
//   frame_done  out  1       1-cycle pulse coincident with the last out_vld of a frame
// BEHAVIOUR
// - Reset (async assert, sync release): dout=0, out_vld=0, frame_done=0; col/row counters=0.
//   The partial-max buffer contents are don't-care.
// - A sample is accepted on each clk edge where in_vld=1.
//   in_vld may drop for any number of cycles mid-frame; counters and buffer hold meanwhile.
// - col counts 0..IN_DIM-1 and wraps to 0, then row increments.
//   After row=IN_DIM-1 / col=IN_DIM-1, both wrap to 0; the next sample starts a new frame.
// - Pair register: at even col, pair<=din.
//   At odd col, pm=max(pair,din), evaluated combinationally.
// - Even row, odd col: buf[col>>1] <= pm. No output.
// - Odd row, odd col: on the next edge, dout<=max(buf[col>>1],pm) and out_vld<=1.
//   Latency is 1 cycle from acceptance of the bottom-right sample of each 2x2 window.
// - frame_done<=1 on the same edge as the output for row=IN_DIM-1, col=IN_DIM-1.
// - All compares are unsigned DATA_W, with no saturation or rescale; dout is bit-exact to an input.
//   On ties, either operand may be taken (values are equal).
// - out_vld and frame_done deassert on the following edge unless another output is produced.
//   dout holds its last value between outputs.
// - Output count: (IN_DIM/2)^2 per frame.
//   The minimum spacing between out_vld pulses is 2 cycles.
// - Back-to-back frames with in_vld held high are supported with no bubble.
//   The first sample of frame N+1 may be accepted on the same edge as frame N's last output is registered.
// - Reset mid-frame discards partial state. The next accepted sample is row 0, col 0.
// - No backpressure: the block accepts every valid sample and has no ready output.
// TESTING
// - Ramp din=0..35, in_vld high 36 cycles.
//   Expect exactly 9 out_vld: dout=7,9,11,19,21,23,31,33,35; frame_done only with 35.
// - Descending ramp din=35..0.
//   Expect dout=35,33,31,23,21,19,11,9,7 (the max is the top-left sample of each window).
// - Ramp with in_vld toggled 1,0,0,1... (random gaps).
//   Expect the same 9 values as the contiguous ramp; no out_vld during gaps except the 1-cycle latency slot.
// - Unsigned check: window {16'h0001,16'hFFFF,16'h8000,16'h7FFF} at the top-left, all other samples 0.
//   Expect first dout=16'hFFFF and the remaining outputs 0.
// - Two ramp frames back-to-back with no idle cycle.
//   Expect 18 outputs, the second 9 equal to the first; frame_done pulses twice.
// - Assert rst_n=0 after 20 samples, release, then send a full ramp.
//   Expect outputs 0 during reset, then exactly the 9 ramp values; no stale output from the aborted frame.

Source files
------------

// File: rtl/maxpool_2x2.sv
// 2x2 stride-2 max pooling over a raster-ordered IN_DIM x IN_DIM stream.
// Horizontal pair maxima of even rows are parked in a half-line buffer and
// combined with the matching pair of the following odd row.
module maxpool_2x2 #(
    parameter int DATA_W = 16,
    parameter int IN_DIM = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              out_vld,
    output logic              frame_done
);

    localparam int CW = (IN_DIM > 2) ? $clog2(IN_DIM) : 1;
    localparam int HW = (IN_DIM > 2) ? $clog2(IN_DIM / 2) : 1;
    localparam logic [CW-1:0] LAST = CW'(IN_DIM - 1);

    logic [CW-1:0]     col;
    logic [CW-1:0]     row;
    logic [DATA_W-1:0] pair;
    logic [DATA_W-1:0] line_buf [0:(1 << HW) - 1];
    logic [HW-1:0]     bidx;
    logic [DATA_W-1:0] pm;
    logic [DATA_W-1:0] pooled;
    logic              win_done;
    logic              last_pos;

    // Window-position decode and unsigned max trees
    always_comb begin
        bidx     = HW'(col >> 1);
        pm       = (din > pair) ? din : pair;
        pooled   = (line_buf[bidx] > pm) ? line_buf[bidx] : pm;
        win_done = in_vld && col[0] && row[0];
        last_pos = (col == LAST) && (row == LAST);
    end

    // Raster position counters, advanced only on accepted samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (in_vld) begin
            if (col == LAST) begin
                col <= '0;
                row <= (row == LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Left sample of each horizontal pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair <= '0;
        end else if (in_vld && !col[0]) begin
            pair <= din;
        end
    end

    // Partial-max line buffer, written on odd columns of even rows; contents need no reset
    always_ff @(posedge clk) begin
        if (in_vld && col[0] && !row[0]) begin
            line_buf[bidx] <= pm;
        end
    end

    // Registered pooled output with one-cycle valid and end-of-frame pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            out_vld    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_vld    <= win_done;
            frame_done <= win_done && last_pos;
            if (win_done) begin
                dout <= pooled;
            end
        end
    end

endmodule

// File: tb/tb_maxpool_2x2.sv
// Scoreboard bench for maxpool_2x2: the driver queues expected pooled values,
// a monitor pops and compares on every out_vld.
module tb_maxpool_2x2;

    logic        clk;
    logic        rst_n;
    logic        in_vld;
    logic [15:0] din;
    logic [15:0] dout;
    logic        out_vld;
    logic        frame_done;

    maxpool_2x2 #(.DATA_W(16), .IN_DIM(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vld     (in_vld),
        .din        (din),
        .dout       (dout),
        .out_vld    (out_vld),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] v;
        bit          fd;
    } exp_t;

    exp_t        sb [$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_out  = 0;
    int          n_fd   = 0;
    logic [15:0] frm  [36];
    logic [15:0] exp9 [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    task automatic push9();
        exp_t e;
        for (int k = 0; k < 9; k++) begin
            e.v  = exp9[k];
            e.fd = (k == 8);
            sb.push_back(e);
        end
    endtask

    task automatic fill_ramp(input bit down);
        for (int k = 0; k < 36; k++) frm[k] = down ? 16'(35 - k) : 16'(k);
    endtask

    task automatic set_ramp_exp();
        exp9 = '{16'd7, 16'd9, 16'd11, 16'd19, 16'd21, 16'd23, 16'd31, 16'd33, 16'd35};
    endtask

    // Drive frm[0..n-1]; gap mode inserts idle cycles after some samples
    task automatic send(input int n, input bit gaps);
        int g;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            in_vld = 1'b1;
            din    = frm[k];
            g = 0;
            if (gaps) g = (k % 3 == 0) ? 2 : int'($urandom_range(0, 1));
            repeat (g) begin
                @(negedge clk);
                in_vld = 1'b0;
                din    = 16'hDEAD;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_vld = 1'b0;
            din    = 16'h0;
        end
    endtask

    // Monitor: every output must match the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_vld) begin
                n_out++;
                if (frame_done) n_fd++;
                if (sb.size() == 0) begin
                    chk("unexpected_out", {16'h0, dout}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("dout", {16'h0, dout}, {16'h0, e.v});
                    chk("frame_done", {31'h0, frame_done}, {31'h0, e.fd});
                end
            end else if (rst_n && frame_done) begin
                chk("frame_done_without_vld", 32'd1, 32'd0);
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        in_vld = 1'b0;
        din    = 16'h0;
        repeat (3) @(negedge clk);
        chk("reset_dout", {16'h0, dout}, 32'h0);
        chk("reset_out_vld", {31'h0, out_vld}, 32'h0);
        chk("reset_frame_done", {31'h0, frame_done}, 32'h0);
        rst_n = 1'b1;
        idle(2);

        // contiguous ascending ramp
        fill_ramp(1'b0);
        set_ramp_exp();
        push9();
        send(36, 1'b0);
        idle(4);

        // descending ramp: top-left of each window wins
        fill_ramp(1'b1);
        exp9 = '{16'd35, 16'd33, 16'd31, 16'd23, 16'd21, 16'd19, 16'd11, 16'd9, 16'd7};
        push9();
        send(36, 1'b0);
        idle(4);

        // ramp with idle gaps
        fill_ramp(1'b0);
        set_ramp_exp();
        push9();
        send(36, 1'b1);
        idle(4);

        // unsigned compare in the top-left window
        for (int k = 0; k < 36; k++) frm[k] = 16'h0;
        frm[0] = 16'h0001;
        frm[1] = 16'hFFFF;
        frm[6] = 16'h8000;
        frm[7] = 16'h7FFF;
        exp9 = '{16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        push9();
        send(36, 1'b0);
        idle(4);

        // two ramp frames back-to-back, no bubble
        fill_ramp(1'b0);
        set_ramp_exp();
        push9();
        push9();
        send(36, 1'b0);
        send(36, 1'b0);
        idle(4);

        // abort a frame after 20 samples: outputs 7,9,11,19 occur before reset
        fill_ramp(1'b0);
        exp9 = '{16'd7, 16'd9, 16'd11, 16'd19, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.v  = exp9[k];
            e.fd = 1'b0;
            sb.push_back(e);
        end
        send(20, 1'b0);
        idle(2);
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midreset_dout", {16'h0, dout}, 32'h0);
            chk("midreset_out_vld", {31'h0, out_vld}, 32'h0);
        end
        rst_n = 1'b1;
        idle(1);
        set_ramp_exp();
        push9();
        send(36, 1'b0);
        idle(6);

        chk("scoreboard_empty", sb.size(), 32'd0);
        chk("output_count", n_out, 32'd67);
        chk("frame_done_count", n_fd, 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
